// File: rtl/branch_predictor_bht.sv
// Branch history table: per-index 2-bit saturating counters.
// Fetch lookup is combinational and trained from EX branch resolution.
// Also keeps resolved-branch and mispredict counters for profiling.
module branch_predictor_bht #(
  parameter int INST_MEMORY_ADDRESS_WIDTH = 32,
  parameter int BHT_ENTRIES               = 16,
  parameter int STAT_WIDTH                = 32
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] fetch_addr,
  output logic                                 predict_take,
  input  logic                                 resolve_valid,
  input  logic [INST_MEMORY_ADDRESS_WIDTH-1:0] resolve_addr,
  input  logic                                 resolve_predicted,
  input  logic                                 resolve_taken,
  output logic                                 mispredict,
  input  logic                                 stat_clear,
  output logic [STAT_WIDTH-1:0]                branch_count,
  output logic [STAT_WIDTH-1:0]                mispredict_count
);

  localparam int IDX_W = $clog2(BHT_ENTRIES);

  // 00 strong-NT, 01 weak-NT, 10 weak-T, 11 strong-T
  logic [1:0]       bht [BHT_ENTRIES];
  logic [IDX_W-1:0] fetch_idx;
  logic [IDX_W-1:0] resolve_idx;
  logic [1:0]       trained;
  logic             unused_addr_bits;

  // Word-aligned index; no tags, so aliasing addresses share an entry.
  assign fetch_idx   = fetch_addr[IDX_W+1:2];
  assign resolve_idx = resolve_addr[IDX_W+1:2];

  assign unused_addr_bits = ^{fetch_addr[1:0], fetch_addr[INST_MEMORY_ADDRESS_WIDTH-1:IDX_W+2],
                              resolve_addr[1:0], resolve_addr[INST_MEMORY_ADDRESS_WIDTH-1:IDX_W+2]};

  // Prediction reads the registered table, so a same-cycle update is not visible yet.
  assign predict_take = bht[fetch_idx][1];

  // Misprediction compares against the prediction carried down the pipe.
  assign mispredict = resolve_valid & (resolve_predicted ^ resolve_taken);

  // Saturating next value for the entry being trained.
  always_comb begin
    trained = bht[resolve_idx];
    if (resolve_taken) begin
      if (trained != 2'b11) trained = trained + 2'd1;
    end else begin
      if (trained != 2'b00) trained = trained - 2'd1;
    end
  end

  // Table storage: reset to weakly-not-taken, train on resolution.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht[i] <= 2'b01;
    end else if (resolve_valid) begin
      bht[resolve_idx] <= trained;
    end
  end

  // Profiling counters; clear wins over increment, both wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (stat_clear) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else begin
      branch_count     <= branch_count + STAT_WIDTH'(resolve_valid);
      mispredict_count <= mispredict_count + STAT_WIDTH'(mispredict);
    end
  end

endmodule

// File: tb/tb_branch_predictor_bht.sv
// Scoreboard bench for branch_predictor_bht: the driver pushes expected
// outputs from an array-based model; a negedge monitor pops and compares.
module tb_branch_predictor_bht;

  localparam int AW = 32;
  localparam int NE = 16;
  localparam int SW = 8;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] fetch_addr;
  logic          predict_take;
  logic          resolve_valid;
  logic [AW-1:0] resolve_addr;
  logic          resolve_predicted;
  logic          resolve_taken;
  logic          mispredict;
  logic          stat_clear;
  logic [SW-1:0] branch_count;
  logic [SW-1:0] mispredict_count;

  branch_predictor_bht #(
    .INST_MEMORY_ADDRESS_WIDTH(AW),
    .BHT_ENTRIES(NE),
    .STAT_WIDTH(SW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .fetch_addr(fetch_addr),
    .predict_take(predict_take),
    .resolve_valid(resolve_valid),
    .resolve_addr(resolve_addr),
    .resolve_predicted(resolve_predicted),
    .resolve_taken(resolve_taken),
    .mispredict(mispredict),
    .stat_clear(stat_clear),
    .branch_count(branch_count),
    .mispredict_count(mispredict_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       pred;
    logic       mis;
    int         bc;
    int         mc;
  } exp_t;

  exp_t q[$];
  int   errors = 0;
  int   checks = 0;

  // Reference model: counter strength 0..3 per entry, plain integer stats.
  int   model_tbl [NE];
  int   model_bc;
  int   model_mc;

  function automatic int idx(input logic [AW-1:0] a);
    return int'((a >> 2) % NE);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NE; i++) model_tbl[i] = 1;
    model_bc = 0;
    model_mc = 0;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every pending expectation with the outputs mid-cycle.
  always @(negedge clk) begin
    while (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      chk("predict_take", int'(predict_take), int'(e.pred));
      chk("mispredict", int'(mispredict), int'(e.mis));
      chk("branch_count", int'(branch_count), e.bc);
      chk("mispredict_count", int'(mispredict_count), e.mc);
    end
  end

  // One clock of stimulus: drive, push expectation, advance, then train the model.
  task automatic cycle(input logic [AW-1:0] fa, input logic rv, input logic [AW-1:0] ra,
                       input logic rp, input logic rt, input logic sc, input logic r);
    exp_t e;
    int   i;
    logic mis;
    rst               = r;
    fetch_addr        = fa;
    resolve_valid     = rv;
    resolve_addr      = ra;
    resolve_predicted = rp;
    resolve_taken     = rt;
    stat_clear        = sc;
    if (r) model_reset();
    mis    = rv && (rp != rt);
    e.pred = (model_tbl[idx(fa)] >= 2);
    e.mis  = mis;
    e.bc   = model_bc;
    e.mc   = model_mc;
    q.push_back(e);
    @(posedge clk);
    #1;
    if (!r) begin
      if (rv) begin
        i = idx(ra);
        model_tbl[i] = rt ? ((model_tbl[i] + 1 > 3) ? 3 : model_tbl[i] + 1)
                          : ((model_tbl[i] - 1 < 0) ? 0 : model_tbl[i] - 1);
      end
      if (sc) begin
        model_bc = 0;
        model_mc = 0;
      end else begin
        model_bc = (model_bc + int'(rv)) % (1 << SW);
        model_mc = (model_mc + int'(mis)) % (1 << SW);
      end
    end
  endtask

  task automatic idle(input logic [AW-1:0] fa);
    cycle(fa, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic resolve(input logic [AW-1:0] a, input logic rp, input logic rt);
    cycle(a, 1'b1, a, rp, rt, 1'b0, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [AW-1:0] fa, ra;
    logic          rv, rp, rt, sc, r;
    model_reset();
    rst = 1'b1; fetch_addr = '0; resolve_valid = 1'b0; resolve_addr = '0;
    resolve_predicted = 1'b0; resolve_taken = 1'b0; stat_clear = 1'b0;
    @(posedge clk);
    #1;

    // Reset sweep: every entry weakly-not-taken, counts zero.
    for (int a = 0; a < 16; a++) cycle(32'(a * 4), 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    idle(32'h44);

    // Saturation up at 0x44, then down.
    resolve(32'h44, 1'b0, 1'b1);
    resolve(32'h44, 1'b1, 1'b1);
    resolve(32'h44, 1'b1, 1'b1);
    idle(32'h44);
    for (int k = 0; k < 4; k++) resolve(32'h44, 1'b1, 1'b0);
    idle(32'h44);

    // Aliasing 0x00 / 0x40, and same-cycle lookup/update hazard at 0x08.
    resolve(32'h00, 1'b0, 1'b1);
    idle(32'h40);
    cycle(32'h08, 1'b1, 32'h08, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(32'h08);

    // Async reset between edges discards trained state.
    cycle(32'h08, 1'b1, 32'h08, 1'b1, 1'b1, 1'b0, 1'b1);
    cycle(32'h08, 1'b1, 32'h08, 1'b0, 1'b1, 1'b0, 1'b0);
    idle(32'h08);

    // Statistics: 10 resolves, 3 mispredicts, then clear with a mispredict.
    for (int k = 0; k < 10; k++) resolve(32'h20 + 32'(k * 4), 1'b0, (k < 3));
    idle(32'h20);
    cycle(32'h20, 1'b1, 32'h24, 1'b1, 1'b0, 1'b1, 1'b0);
    idle(32'h20);

    // Loop branch at 0x10 taken 4x then falls through, carrying the table's own prediction.
    for (int k = 0; k < 5; k++) begin
      rt = (k < 4);
      rp = (model_tbl[idx(32'h10)] >= 2);
      resolve(32'h10, rp, rt);
    end
    idle(32'h10);

    // Counter wrap: 2^SW resolves brings branch_count back to 0.
    cycle(32'h0, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1);
    for (int k = 0; k < (1 << SW); k++) resolve(32'h30, 1'b1, 1'b1);
    idle(32'h30);

    // Randomized traffic against the model, including occasional clear/reset.
    for (int k = 0; k < 400; k++) begin
      fa = $urandom;
      ra = $urandom_range(0, 1) ? {$urandom} : 32'($urandom_range(0, 7) * 4);
      rv = ($urandom_range(0, 3) != 0);
      rp = 1'($urandom);
      rt = 1'($urandom);
      sc = ($urandom_range(0, 40) == 0);
      r  = ($urandom_range(0, 80) == 0);
      cycle(fa, rv, ra, rp, rt, sc, r);
    end
    idle(32'h0);

    @(negedge clk);
    #1;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/branch_predictor_bht.md
# branch_predictor_bht

Branch history table that supplies the fetch-stage taken/not-taken prediction and resolves it in EX. It sits directly upstream of the program counter. Each cycle it indexes a table of 2-bit saturating counters with the current fetch address to drive the PC's `branch_decision_take`. When the ID/EX branch resolves, it trains the table and raises `branch_decision_incorrect_flag` on a misprediction. It also keeps branch and mispredict counts for power/performance profiling.

## Interface
- `INST_MEMORY_ADDRESS_WIDTH`, 32: fetch/branch address width.
- `BHT_ENTRIES`, 16: number of counters; power of two, 4..256. `IDX_W = log2(BHT_ENTRIES)`.
- `STAT_WIDTH`, 32: width of the statistics counters.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset, asynchronous, active-high.
- `fetch_addr`  in  `INST_MEMORY_ADDRESS_WIDTH`  current PC (`inst_addr`).
- `predict_take`  out  1  prediction for `fetch_addr`; drives the PC's `branch_decision_take`.
- `resolve_valid`  in  1  a conditional branch in EX is resolving this cycle.
- `resolve_addr`  in  `INST_MEMORY_ADDRESS_WIDTH`  branch address (`idex_branch_inst_addr`).
- `resolve_predicted`  in  1  prediction carried with the branch (`idex_branch_decision`).
- `resolve_taken`  in  1  actual outcome from the EX comparator.
- `mispredict`  out  1  drives the PC's `branch_decision_incorrect_flag`.
- `stat_clear`  in  1  synchronous clear of the statistics counters.
- `branch_count`  out  `STAT_WIDTH`  resolved branches.
- `mispredict_count`  out  `STAT_WIDTH`  mispredicted branches.

## Operation
- Table: `BHT_ENTRIES` × 2-bit counters. Encoding: 00 strongly-not-taken, 01 weakly-not-taken, 10 weakly-taken, 11 strongly-taken.
- Index = `addr[IDX_W+1:2]`. Bits [1:0] are ignored. There are no tags, so aliasing addresses share an entry.
- `predict_take` = bit 1 of `table[index(fetch_addr)]`. It is purely combinational from `fetch_addr` and the registered table.
- `mispredict` = `resolve_valid & (resolve_predicted != resolve_taken)`. It is combinational and uses the carried prediction, not the current table contents.
- Training on the `clk` edge when `resolve_valid`=1 updates entry `e = index(resolve_addr)`:
  - If `resolve_taken`, then `e` = min(`e`+1, 3).
  - Otherwise `e` = max(`e`−1, 0).
  - Saturation is required: 11 stays 11 and 00 stays 00.
- With `resolve_valid`=0 the table is unchanged. PC `pc_hold` is not an input; EX resolution is trusted to be valid only once per branch.
- Statistics on each `clk` edge:
  - `stat_clear`=1: both counters are set to 0. This has priority over increments in the same cycle.
  - Otherwise, `branch_count` += `resolve_valid`, and `mispredict_count` += `mispredict`.
  - Both counters wrap modulo 2^`STAT_WIDTH` (all-ones + 1 → 0).

## Timing
- Reset (async, immediate):
  - All table entries = 01, so `predict_take`=0 for every address.
  - `branch_count` = `mispredict_count` = 0.
  - `mispredict` follows its inputs (combinational; 0 when `resolve_valid`=0).
- Prediction latency is 0 cycles: valid in the same cycle as `fetch_addr`.
- Training latency is 1 cycle: the update becomes visible to `predict_take` from the cycle after the `resolve_valid` edge.
- Simultaneous lookup and update of the same index: `predict_take` returns the pre-update value that cycle.
- Reset asserted mid-operation: any pending update is discarded, and the state returns to reset values immediately. The first training edge after deassertion operates on entries = 01.
- Statistics outputs are registered and reflect events up to the previous edge.

## Test plan
- **Reset:** assert `rst`, then sweep `fetch_addr` 0x00..0x3C step 4 → `predict_take`=0 everywhere, both counts 0. Assert `rst` asynchronously between edges → outputs clear without a clock.
- **Saturation up:**
  - Resolve addr 0x44 taken ×3 (predicted=0,1,1) → entry 1 goes 01→10→11→11.
  - `predict_take`@0x44 = 1 from the cycle after the first edge.
  - `mispredict` pulses only on the first resolve.
- **Saturation down:** from 11, resolve 0x44 not-taken ×4 → 10,01,00,00. `predict_take`@0x44 = 1,0,0,0 after each edge.
- **Aliasing and same-cycle hazard:**
  - Train 0x00 taken once, then check `fetch_addr`=0x40 (same index 0 at 16 entries) → `predict_take`=1.
  - Present `fetch_addr`=0x08 while resolving 0x08 taken → `predict_take`=0 that cycle, 1 next cycle.
- **Statistics:**
  - 10 resolves with 3 mispredicts → `branch_count`=10, `mispredict_count`=3.
  - `stat_clear` together with a mispredicting resolve → both counts 0.
  - Preload near max (force `branch_count`=0xFFFFFFFF), then one resolve → 0.
- **Pipeline with program_counter:**
  - Loop branch at 0x10 with offset −16, taken 4× then falls through.
  - Mispredicts are asserted only on the first and last iterations.
  - The PC redirects to 0x14 on exit.
